// File: rtl/writeback_queue.sv
// In-order writeback FIFO feeding the register file write port; retires one write per clock.
// Optional pending-value forwarding to decode is built only when WB_FORWARD_EN is defined.
module writeback_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_reg,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_reg,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  stall,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] fwd_reg1,
  output logic                  fwd_hit1,
  output logic [DATA_WIDTH-1:0] fwd_data1,
  input  logic [ADDR_WIDTH-1:0] fwd_reg2,
  output logic                  fwd_hit2,
  output logic [DATA_WIDTH-1:0] fwd_data2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] TWO_C   = CW'(2);

  logic [ADDR_WIDTH-1:0] q_reg  [DEPTH];
  logic [DATA_WIDTH-1:0] q_data [DEPTH];
  logic [PW-1:0]         head, tail, alu_slot;
  logic [CW-1:0]         count, free;
  logic                  pop, mem_req, alu_req, mem_ok, alu_ok, drop;

  // The same-cycle pop is credited to free space so a full queue can still accept one entry.
  always_comb begin
    pop      = (count != '0);
    free     = DEPTH_C - count + CW'(pop);
    mem_req  = mem_valid && (mem_reg != '0);
    alu_req  = alu_valid && (alu_reg != '0);
    mem_ok   = mem_req && (free >= ONE_C);
    alu_ok   = alu_req && (free >= (mem_ok ? TWO_C : ONE_C));
    drop     = (mem_req && !mem_ok) || (alu_req && !alu_ok);
    alu_slot = mem_ok ? tail + PW'(1) : tail;
  end

  assign stall = (count > (DEPTH_C - TWO_C));

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (mem_ok) begin
        q_reg[tail]  <= mem_reg;
        q_data[tail] <= mem_data;
      end
      if (alu_ok) begin
        q_reg[alu_slot]  <= alu_reg;
        q_data[alu_slot] <= alu_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      RegWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      head     <= head + PW'(pop);
      tail     <= tail + PW'(mem_ok) + PW'(alu_ok);
      count    <= count + CW'(mem_ok) + CW'(alu_ok) - CW'(pop);
      RegWrite <= pop;
      if (drop)
        overflow <= 1'b1;
      if (pop) begin
        write_reg  <= q_reg[head];
        write_data <= q_data[head];
      end
    end
  end

`ifdef WB_FORWARD_EN
  // Scan oldest to youngest so the youngest match overrides; the output register is oldest of all.
  function automatic logic [DATA_WIDTH:0] lookup(input logic [ADDR_WIDTH-1:0] r);
    logic [DATA_WIDTH:0] res;
    logic [PW-1:0]       idx;
    res = '0;
    if (RegWrite && (write_reg == r))
      res = {1'b1, write_data};
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (q_reg[idx] == r))
        res = {1'b1, q_data[idx]};
    end
    if (r == '0)
      res = '0;
    return res;
  endfunction

  always_comb {fwd_hit1, fwd_data1} = lookup(fwd_reg1);
  always_comb {fwd_hit2, fwd_data2} = lookup(fwd_reg2);
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_reg1, fwd_reg2};
  assign fwd_hit1   = 1'b0;
  assign fwd_data1  = '0;
  assign fwd_hit2   = 1'b0;
  assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: spec-level acceptance model plus an in-order scoreboard.
module tb_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, alu_valid;
  logic [4:0]  mem_reg, alu_reg;
  logic [31:0] mem_data, alu_data;
  logic        stall, overflow, RegWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  fwd_reg1, fwd_reg2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;

  writeback_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .stall(stall), .overflow(overflow),
    .write_reg(write_reg), .write_data(write_data), .RegWrite(RegWrite),
    .fwd_reg1(fwd_reg1), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_reg2(fwd_reg2), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [36:0] sb[$];
  int          m_count = 0;
  logic        m_ovf = 1'b0;
  logic        exp_rw = 1'b0;
  logic [4:0]  last_reg = '0;
  logic [31:0] last_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict acceptance, then check outputs 1 time unit after the edge.
  task automatic cycle(input logic rst,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic av, input logic [4:0] ar, input logic [31:0] ad);
    logic        pop, mreq, areq, macc, aacc;
    int          free;
    logic [36:0] ent;
    reset = rst; mem_valid = mv; mem_reg = mr; mem_data = md;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    if (rst) begin
      m_count = 0; sb.delete(); m_ovf = 1'b0; exp_rw = 1'b0;
      last_reg = '0; last_data = '0;
    end else begin
      pop  = (m_count > 0);
      free = DEPTH - m_count + (pop ? 1 : 0);
      mreq = mv && (mr != 5'd0);
      areq = av && (ar != 5'd0);
      macc = mreq && (free >= 1);
      aacc = areq && (free >= (macc ? 2 : 1));
      if ((mreq && !macc) || (areq && !aacc)) m_ovf = 1'b1;
      if (macc) sb.push_back({mr, md});
      if (aacc) sb.push_back({ar, ad});
      exp_rw  = pop;
      m_count = m_count + (macc ? 1 : 0) + (aacc ? 1 : 0) - (pop ? 1 : 0);
    end
    @(posedge clk);
    #1;
    chk("reg_write", RegWrite, exp_rw);
    if (exp_rw && sb.size() > 0) begin
      ent = sb.pop_front();
      last_reg = ent[36:32]; last_data = ent[31:0];
    end
    chk("write_reg", write_reg, last_reg);
    chk("write_data", write_data, last_data);
    chk("stall", stall, (DEPTH - m_count) < 2);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic check_fwd(input logic [4:0] r1, input logic [4:0] r2);
    logic        h1, h2;
    logic [31:0] d1, d2;
    fwd_reg1 = r1; fwd_reg2 = r2;
    #1;
    h1 = 1'b0; d1 = '0; h2 = 1'b0; d2 = '0;
`ifdef WB_FORWARD_EN
    if (exp_rw && last_reg == r1) begin h1 = 1'b1; d1 = last_data; end
    if (exp_rw && last_reg == r2) begin h2 = 1'b1; d2 = last_data; end
    foreach (sb[i]) begin
      if (sb[i][36:32] == r1) begin h1 = 1'b1; d1 = sb[i][31:0]; end
      if (sb[i][36:32] == r2) begin h2 = 1'b1; d2 = sb[i][31:0]; end
    end
    if (r1 == 5'd0) begin h1 = 1'b0; d1 = '0; end
    if (r2 == 5'd0) begin h2 = 1'b0; d2 = '0; end
`endif
    chk("fwd_hit1", fwd_hit1, h1);
    chk("fwd_data1", fwd_data1, d1);
    chk("fwd_hit2", fwd_hit2, h2);
    chk("fwd_data2", fwd_data2, d2);
  endtask

  initial begin
    reset = 1'b1; mem_valid = 1'b0; alu_valid = 1'b0;
    mem_reg = '0; alu_reg = '0; mem_data = '0; alu_data = '0;
    fwd_reg1 = '0; fwd_reg2 = '0;

    // Reset for two cycles, then idle.
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 3; k++) idle();

    // Single ALU push: one-cycle pulse after the following edge.
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'habcdef12);
    check_fwd(5'd3, 5'd4);
    idle();
    chk("single_write_reg", write_reg, 5'd3);
    chk("single_write_data", write_data, 32'habcdef12);
    check_fwd(5'd3, 5'd0);
    idle();
    idle();

    // Dual push to the same register: retired in order, not merged.
    cycle(1'b0, 1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
    check_fwd(5'd5, 5'd6);
    idle();
    chk("dual_first", write_data, 32'h11);
    check_fwd(5'd5, 5'd5);
    idle();
    chk("dual_second", write_data, 32'h22);
    check_fwd(5'd5, 5'd0);
    idle();
    check_fwd(5'd5, 5'd3);

    // Zero register is discarded.
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hdead0000);
    check_fwd(5'd0, 5'd0);
    idle();
    idle();

    // Mem-only push.
    cycle(1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0);
    idle();
    chk("mem_only", write_reg, 5'd7);
    idle();

    // Fill with dual pushes ignoring stall; the fourth cycle drops the ALU entry.
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, 5'(8 + 2 * k), 32'h100 + 32'(k), 1'b1, 5'(9 + 2 * k), 32'h200 + 32'(k));
      if (k == 1) check_fwd(5'd9, 5'd10);
      if (k == 2) chk("fill_ovf_clear", overflow, 1'b0);
    end
    chk("fill_ovf_set", overflow, 1'b1);
    chk("fill_stall", stall, 1'b1);
    check_fwd(5'd14, 5'd15);
    for (int k = 0; k < 12 && sb.size() > 0; k++) idle();
    chk("fill_drained", 64'(sb.size()), 64'd0);
    idle();
    chk("ovf_sticky", overflow, 1'b1);

    // Reset with pending entries discards them.
    cycle(1'b0, 1'b1, 5'd20, 32'h2020, 1'b1, 5'd21, 32'h2121);
    cycle(1'b0, 1'b1, 5'd22, 32'h2222, 1'b1, 5'd23, 32'h2323);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("rst_regwrite", RegWrite, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    check_fwd(5'd22, 5'd23);
    for (int k = 0; k < 4; k++) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
